sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter NOTE_LEN, default 16, meaning the clock cycles each note sounds (minimum 1).
REQ-002 SHALL have parameter GAP_LEN, default 4, meaning the silent clock cycles between consecutive notes (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 24, meaning the width of the duration counter (must hold max(NOTE_LEN, GAP_LEN)).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port nRst  input  1  synchronous, active-high reset (reset applied when nRst=1 at a rising clk edge).
REQ-006 SHALL have port goodColl  input  1  single-cycle pulse: snake ate food.
REQ-007 SHALL have port badColl  input  1  single-cycle pulse: snake died.
REQ-008 SHALL have port freq  output  9  note frequency in Hz driven to the oscillator.
REQ-009 SHALL have port playSound  output  1  oscillator enable.
REQ-010 SHALL have port busy  output  1  high while a sequence is in progress.

Function
REQ-011 SHALL use states IDLE, NOTE, GAP; the current sequence (EAT or DIE) and note index (0..2) SHALL be registered.
REQ-012 The EAT sequence SHALL be notes 262 then 440; the DIE sequence SHALL be 440, 311, 262.
REQ-013 SHALL make all outputs registered; a trigger sampled at edge N SHALL give playSound=1, busy=1, freq=first note from edge N (visible in cycle N+1).
REQ-014 NOTE SHALL hold freq=current note and playSound=1 for exactly NOTE_LEN cycles.
REQ-015 After a non-final note, GAP SHALL hold playSound=0 and freq=0 for exactly GAP_LEN cycles, then enter NOTE with the next note.
REQ-016 After the final note, the block SHALL go directly to IDLE with playSound=0, freq=0, busy=0 and no trailing gap.
REQ-017 In IDLE, playSound=0, freq=0, busy=0.
REQ-018 Busy time SHALL be 2*NOTE_LEN+GAP_LEN cycles for EAT (36 at default) and 3*NOTE_LEN+2*GAP_LEN cycles for DIE (56 at default).
REQ-019 If goodColl and badColl are both high in the same cycle, DIE SHALL win.
REQ-020 badColl during EAT (any state) SHALL abort EAT and restart DIE at note 0 with the counter cleared, using the REQ-013 timing.
REQ-021 badColl during DIE SHALL restart DIE from note 0.
REQ-022 goodColl during EAT SHALL restart EAT from note 0.
REQ-023 goodColl during DIE SHALL be ignored.
REQ-024 The duration counter SHALL clear on every state entry and SHALL never wrap; a transition SHALL occur when the count reaches LEN-1.

Reset
REQ-025 nRst=1 at an edge SHALL force IDLE, clear the counter, sequence and index, and set freq=0, playSound=0, busy=0 on that edge.
REQ-026 Reset SHALL take priority over goodColl and badColl in the same cycle.
REQ-027 Reset mid-sequence SHALL silence the outputs immediately; the sequence SHALL NOT resume.

Verification
REQ-028 Reset, then no triggers for 100 cycles -> freq=0, playSound=0, busy=0 throughout.
REQ-029 goodColl pulse -> freq=262 for 16 cycles, then freq=0/playSound=0 for 4 cycles, then 440 for 16 cycles, then IDLE; busy high for exactly 36 cycles.
REQ-030 badColl pulse -> 440 (16 cycles), gap (4), 311 (16), gap (4), 262 (16), then IDLE; busy high for 56 cycles.
REQ-031 goodColl, then badColl 10 cycles later -> from the next edge freq=440 and the full DIE sequence plays; a goodColl injected during DIE -> no change in the outputs.
REQ-032 goodColl and badColl in the same cycle -> DIE sequence plays; nRst=1 in cycle 20 of DIE -> all outputs 0 on the next cycle and they stay 0.
REQ-033 Model freq/playSound against a bench oscillator model -> the at_max period during 440 is 88-89 cycles at 10 MHz / 256 scaling.

Source files
------------

// File: rtl/sound_sequencer.sv
// sound_sequencer
//   Plays short note sequences on a tone oscillator when collision pulses
//   arrive. There are two sequences: EAT (262 Hz, 440 Hz) and DIE
//   (440 Hz, 311 Hz, 262 Hz). Each note lasts NOTE_LEN cycles. Consecutive
//   notes are separated by GAP_LEN silent cycles. The final note is not
//   followed by a gap. All outputs are registered.
//
// Ports
//   clk        in   system clock, rising edge
//   nRst       in   synchronous reset, active HIGH despite the name
//   goodColl   in   one-cycle pulse, snake ate food   -> EAT sequence
//   badColl    in   one-cycle pulse, snake died       -> DIE sequence
//   freq       out  [8:0] note frequency in Hz, 0 when silent
//   playSound  out  oscillator enable
//   busy       out  high while a sequence is in progress
//
// state   | meaning
// IDLE    | silent, waiting for a collision pulse
// NOTE    | sounding note idx of sequence seq
// GAP     | silent spacing before note idx+1
module sound_sequencer #(
  parameter int NOTE_LEN = 16,
  parameter int GAP_LEN  = 4,
  parameter int CNT_W    = 24
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  output logic [8:0] freq,
  output logic       playSound,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NOTE = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic SEQ_EAT = 1'b0;
  localparam logic SEQ_DIE = 1'b1;

  localparam logic [8:0] F_C4  = 9'd262;
  localparam logic [8:0] F_DS4 = 9'd311;
  localparam logic [8:0] F_A4  = 9'd440;

  localparam logic [CNT_W-1:0] NOTE_TC = CNT_W'(NOTE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_LEN - 1);

  logic [1:0]       state;
  logic             seq;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic start_die;
  logic start_eat;
  logic note_done;
  logic gap_done;
  logic last_note;

  function automatic logic [8:0] note_freq(input logic s, input logic [1:0] i);
    logic [8:0] f;
    f = F_C4;
    if (s == SEQ_EAT) begin
      f = (i == 2'd0) ? F_C4 : F_A4;
    end else begin
      case (i)
        2'd0:    f = F_A4;
        2'd1:    f = F_DS4;
        default: f = F_C4;
      endcase
    end
    return f;
  endfunction

  // badColl always wins. A goodColl is ignored only while DIE is running.
  always_comb begin
    start_die = badColl;
    start_eat = goodColl && !((state != ST_IDLE) && (seq == SEQ_DIE));
    note_done = (state == ST_NOTE) && (cnt == NOTE_TC);
    gap_done  = (state == ST_GAP)  && (cnt == GAP_TC);
    last_note = (seq == SEQ_DIE) ? (idx == 2'd2) : (idx == 2'd1);
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state     <= ST_IDLE;
      seq       <= SEQ_EAT;
      idx       <= 2'd0;
      cnt       <= '0;
      freq      <= 9'd0;
      playSound <= 1'b0;
      busy      <= 1'b0;
    end else if (start_die || start_eat) begin
      // A trigger (re)starts a sequence at note 0 from any state.
      state     <= ST_NOTE;
      seq       <= start_die ? SEQ_DIE : SEQ_EAT;
      idx       <= 2'd0;
      cnt       <= '0;
      freq      <= start_die ? F_A4 : F_C4;
      playSound <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt       <= '0;
          freq      <= 9'd0;
          playSound <= 1'b0;
          busy      <= 1'b0;
        end
        ST_NOTE: begin
          if (note_done) begin
            cnt       <= '0;
            freq      <= 9'd0;
            playSound <= 1'b0;
            if (last_note) begin
              state <= ST_IDLE;
              idx   <= 2'd0;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state     <= ST_NOTE;
            idx       <= idx + 2'd1;
            cnt       <= '0;
            freq      <= note_freq(seq, idx + 2'd1);
            playSound <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          idx       <= 2'd0;
          cnt       <= '0;
          freq      <= 9'd0;
          playSound <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer
//   Directed bench for sound_sequencer. The main instance uses the default
//   timing. A second instance uses long notes, so that a 440 Hz tone lasts
//   long enough to measure the oscillator period.
module tb_sound_sequencer;

  logic       tb_clk = 1'b0;
  logic       nRst;
  logic       goodColl;
  logic       badColl;
  logic [8:0] freq;
  logic       playSound;
  logic       busy;

  logic       good_long;
  logic       bad_long;
  logic [8:0] freq_long;
  logic       play_long;
  logic       busy_long;

  int n_vec = 0;
  int n_err = 0;

  always #5 tb_clk = ~tb_clk;

  sound_sequencer u_dut (
    .clk       (tb_clk),
    .nRst      (nRst),
    .goodColl  (goodColl),
    .badColl   (badColl),
    .freq      (freq),
    .playSound (playSound),
    .busy      (busy)
  );

  sound_sequencer #(.NOTE_LEN(400), .GAP_LEN(4), .CNT_W(24)) u_long (
    .clk       (tb_clk),
    .nRst      (nRst),
    .goodColl  (good_long),
    .badColl   (bad_long),
    .freq      (freq_long),
    .playSound (play_long),
    .busy      (busy_long)
  );

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // Expected {freq, playSound, busy} in cycle k after the trigger edge
  // (k=1 is the first cycle after that edge), for 16-cycle notes and 4-cycle gaps.
  function automatic logic [10:0] exp_out(input bit die, input int k);
    logic [10:0] r;
    r = 11'd0;
    if (!die) begin
      if (k >= 1 && k <= 16)       r = {9'd262, 2'b11};
      else if (k >= 17 && k <= 20) r = {9'd0,   2'b01};
      else if (k >= 21 && k <= 36) r = {9'd440, 2'b11};
    end else begin
      if (k >= 1 && k <= 16)       r = {9'd440, 2'b11};
      else if (k >= 17 && k <= 20) r = {9'd0,   2'b01};
      else if (k >= 21 && k <= 36) r = {9'd311, 2'b11};
      else if (k >= 37 && k <= 40) r = {9'd0,   2'b01};
      else if (k >= 41 && k <= 56) r = {9'd262, 2'b11};
    end
    return r;
  endfunction

  task automatic run_check(input string name, input bit die, input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      logic [10:0] got;
      logic [10:0] want;
      got  = {freq, playSound, busy};
      want = exp_out(die, k);
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s k=%0d: got freq=%0d play=%0b busy=%0b, want freq=%0d play=%0b busy=%0b",
                 name, k, got[10:2], got[1], got[0], want[10:2], want[1], want[0]);
      end
      step();
    end
  endtask

  task automatic test_reset();
    nRst = 1'b1; goodColl = 1'b1; badColl = 1'b1;
    step();
    step();
    run_check("reset_priority", 0, 1000, 1001);
    nRst = 1'b0; goodColl = 1'b0; badColl = 1'b0;
    run_check("idle_100", 0, 1000, 1099);
  endtask

  task automatic test_eat();
    goodColl = 1'b1; step(); goodColl = 1'b0;
    run_check("eat", 0, 1, 40);
  endtask

  task automatic test_die();
    badColl = 1'b1; step(); badColl = 1'b0;
    run_check("die", 1, 1, 60);
  endtask

  task automatic test_eat_restart();
    goodColl = 1'b1; step(); goodColl = 1'b0;
    run_check("eat_pre", 0, 1, 7);
    goodColl = 1'b1; step(); goodColl = 1'b0;
    run_check("eat_restart", 0, 1, 40);
  endtask

  task automatic test_die_restart();
    badColl = 1'b1; step(); badColl = 1'b0;
    run_check("die_pre", 1, 1, 30);
    badColl = 1'b1; step(); badColl = 1'b0;
    run_check("die_restart", 1, 1, 60);
  endtask

  task automatic test_abort_eat();
    goodColl = 1'b1; step(); goodColl = 1'b0;
    run_check("abort_eat_pre", 0, 1, 9);
    badColl = 1'b1; step(); badColl = 1'b0;
    run_check("abort_die", 1, 1, 20);
    goodColl = 1'b1;
    run_check("die_ignore_good", 1, 21, 21);
    goodColl = 1'b0;
    run_check("die_after_good", 1, 22, 60);
    goodColl = 1'b1; step(); goodColl = 1'b0;
    run_check("abort_gap_pre", 0, 1, 18);
    badColl = 1'b1; step(); badColl = 1'b0;
    run_check("abort_gap_die", 1, 1, 60);
  endtask

  task automatic test_both_reset();
    goodColl = 1'b1; badColl = 1'b1; step();
    goodColl = 1'b0; badColl = 1'b0;
    run_check("both_die", 1, 1, 19);
    nRst = 1'b1;
    run_check("both_die_c20", 1, 20, 20);
    nRst = 1'b0;
    run_check("after_reset", 0, 1000, 1059);
  endtask

  // Phase-accumulator oscillator: one at_max event every 10 MHz / (256 * freq) cycles.
  task automatic test_osc();
    longint acc;
    int     last_hit;
    int     n_int;
    int     interval;
    acc = 0; last_hit = -1; n_int = 0;
    bad_long = 1'b1; step(); bad_long = 1'b0;
    n_vec++;
    if ({freq_long, play_long, busy_long} !== {9'd440, 2'b11}) begin
      n_err++;
      $display("FAIL osc_start: got freq=%0d play=%0b busy=%0b, want freq=440 play=1 busy=1",
               freq_long, play_long, busy_long);
    end
    for (int c = 1; c <= 400; c++) begin
      if (play_long) begin
        acc += longint'(freq_long) * 256;
        if (acc >= 64'd10_000_000) begin
          acc -= 10_000_000;
          if (last_hit >= 0) begin
            interval = c - last_hit;
            n_int++;
            n_vec++;
            if (interval < 88 || interval > 89) begin
              n_err++;
              $display("FAIL osc_period: got %0d cycles, want 88..89", interval);
            end
          end
          last_hit = c;
        end
      end
      step();
    end
    n_vec++;
    if (n_int < 2) begin
      n_err++;
      $display("FAIL osc_intervals: got %0d periods, want at least 2", n_int);
    end
    nRst = 1'b1; step(); nRst = 1'b0;
  endtask

  initial begin
    nRst = 1'b1; goodColl = 1'b0; badColl = 1'b0;
    good_long = 1'b0; bad_long = 1'b0;
    test_reset();
    test_eat();
    test_die();
    test_eat_restart();
    test_die_restart();
    test_abort_eat();
    test_both_reset();
    test_osc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
